// File: rtl/id_stage.sv
// Decode stage: register file, field/immediate extraction, ID/EX register.
// Define ID_WB_BYPASS_EN to forward same-edge write-back into the operands.
module id_stage #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      inst,
   input  logic [WIDTH-1:0] pc,
   input  logic             inst_valid,
   input  logic             stall,
   input  logic             flush,
   input  logic             wb_we,
   input  logic [4:0]       wb_rd,
   input  logic [WIDTH-1:0] wb_data,
   output logic             id_valid,
   output logic [WIDTH-1:0] id_pc,
   output logic [WIDTH-1:0] rs1_data,
   output logic [WIDTH-1:0] rs2_data,
   output logic [WIDTH-1:0] imm,
   output logic [4:0]       rd,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [6:0]       opcode,
   output logic [2:0]       funct3,
   output logic             funct7b5
);

   logic [WIDTH-1:0] regs [NREGS];
   logic [6:0]       op_w;
   logic [4:0]       rs1_a;
   logic [4:0]       rs2_a;
   logic             wr_en;
   logic [WIDTH-1:0] rf1;
   logic [WIDTH-1:0] rf2;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic [31:0]      imm32;
   logic [WIDTH-1:0] imm_ext;
   logic             is_i;
   logic             is_s;
   logic             is_b;
   logic             is_u;
   logic             is_j;

   assign op_w  = inst[6:0];
   assign rs1_a = inst[19:15];
   assign rs2_a = inst[24:20];
   assign wr_en = wb_we && (wb_rd != 5'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wb_rd] <= wb_data;
      end
   end

   assign rf1 = (rs1_a == 5'd0) ? '0 : regs[rs1_a];
   assign rf2 = (rs2_a == 5'd0) ? '0 : regs[rs2_a];

`ifdef ID_WB_BYPASS_EN
   assign op1 = (wr_en && wb_rd == rs1_a) ? wb_data : rf1;
   assign op2 = (wr_en && wb_rd == rs2_a) ? wb_data : rf2;
`else
   assign op1 = rf1;
   assign op2 = rf2;
`endif

   assign is_i = (op_w == 7'b0000011) || (op_w == 7'b0010011) ||
                 (op_w == 7'b1100111);
   assign is_s = (op_w == 7'b0100011);
   assign is_b = (op_w == 7'b1100011);
   assign is_u = (op_w == 7'b0110111) || (op_w == 7'b0010111);
   assign is_j = (op_w == 7'b1101111);

   always_comb begin
      imm32 = '0;
      unique case (1'b1)
         is_i: imm32 = {{20{inst[31]}}, inst[31:20]};
         is_s: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         is_b: imm32 = {{19{inst[31]}}, inst[31], inst[7],
                        inst[30:25], inst[11:8], 1'b0};
         is_u: imm32 = {inst[31:12], 12'b0};
         is_j: imm32 = {{11{inst[31]}}, inst[31], inst[19:12],
                        inst[20], inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm_ext = WIDTH'($signed(imm32));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_valid <= 1'b0;
         id_pc    <= '0;
         rs1_data <= '0;
         rs2_data <= '0;
         imm      <= '0;
         rd       <= '0;
         rs1      <= '0;
         rs2      <= '0;
         opcode   <= '0;
         funct3   <= '0;
         funct7b5 <= 1'b0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (stall) begin
`ifdef ID_WB_BYPASS_EN
         // held operands must not go stale while waiting
         if (wr_en && wb_rd == rs1) rs1_data <= wb_data;
         if (wr_en && wb_rd == rs2) rs2_data <= wb_data;
`endif
      end else begin
         id_valid <= inst_valid;
         id_pc    <= pc;
         rs1_data <= op1;
         rs2_data <= op2;
         imm      <= imm_ext;
         rd       <= inst[11:7];
         rs1      <= rs1_a;
         rs2      <= rs2_a;
         opcode   <= op_w;
         funct3   <= inst[14:12];
         funct7b5 <= inst[30];
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Directed scoreboard bench for id_stage.
// Expected ID/EX contents are queued on drive and popped after the edge.
module tb_id_stage;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
   } obs_t;

   logic        clk;
   logic        reset;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;
   logic        stall;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] imm;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b5;

   obs_t        got;
   obs_t        last;
   obs_t        sb[$];
   logic [31:0] rf[32];
   int          checks;
   int          errors;

   id_stage dut (
      .clk(clk), .reset(reset), .inst(inst), .pc(pc),
      .inst_valid(inst_valid), .stall(stall), .flush(flush),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .id_valid(id_valid), .id_pc(id_pc), .rs1_data(rs1_data),
      .rs2_data(rs2_data), .imm(imm), .rd(rd), .rs1(rs1), .rs2(rs2),
      .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5)
   );

   assign got = {id_valid, id_pc, rs1_data, rs2_data, imm, rd,
                 rs1, rs2, opcode, funct3, funct7b5};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rd_model(
      input logic [4:0] idx, input logic we,
      input logic [4:0] wrd, input logic [31:0] wd);
      if (idx == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
      if (we && wrd == idx) return wd;
`endif
      return rf[idx];
   endfunction

   task automatic check(input string tag, input obs_t e);
      checks++;
      assert (got === e) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, e);
      end
   endtask

   task automatic cyc(
      input string tag, input logic [31:0] i, input logic [31:0] p,
      input logic v, input logic st, input logic fl,
      input logic we, input logic [4:0] wrd, input logic [31:0] wd,
      input logic [31:0] ei);
      obs_t e;
      inst = i; pc = p; inst_valid = v; stall = st; flush = fl;
      wb_we = we; wb_rd = wrd; wb_data = wd;
      e = last;
      if (fl) begin
         e.v = 1'b0;
      end else if (st) begin
`ifdef ID_WB_BYPASS_EN
         if (we && wrd != 0 && wrd == last.rs1) e.r1 = wd;
         if (we && wrd != 0 && wrd == last.rs2) e.r2 = wd;
`endif
      end else begin
         e.v   = v;
         e.pc  = p;
         e.r1  = rd_model(i[19:15], we, wrd, wd);
         e.r2  = rd_model(i[24:20], we, wrd, wd);
         e.imm = ei;
         e.rd  = i[11:7];
         e.rs1 = i[19:15];
         e.rs2 = i[24:20];
         e.op  = i[6:0];
         e.f3  = i[14:12];
         e.f7  = i[30];
      end
      sb.push_back(e);
      last = e;
      @(posedge clk);
      #1;
      if (we && wrd != 0) rf[wrd] = wd;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         check(tag, sb.pop_front());
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < 32; k++) rf[k] = 32'd0;
      last = '0;
      sb.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear_model();
      reset = 1'b0;
      inst = '0; pc = '0; inst_valid = 0; stall = 0; flush = 0;
      wb_we = 0; wb_rd = '0; wb_data = '0;
      #12;
      check("reset_init", '0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      cyc("wb_x5", 32'h0, 32'h0, 0, 0, 0, 1, 5'd5, 32'h1234, 32'h0);
      cyc("addi", 32'h00528313, 32'h100, 1, 0, 0, 0, 5'd0, 32'h0, 32'd5);
      cyc("wb_x0", 32'h00000013, 32'h104, 1, 0, 0, 1, 5'd0, 32'hFFFF, 32'h0);
      cyc("rd_x0", 32'h00000013, 32'h108, 1, 0, 0, 0, 5'd0, 32'h0, 32'h0);
      cyc("imm_b", 32'hFE000EE3, 32'h10C, 1, 0, 0, 0, 5'd0, 32'h0,
          32'hFFFFFFFC);
      cyc("imm_j", 32'h800000EF, 32'h110, 1, 0, 0, 0, 5'd0, 32'h0,
          32'hFFF00000);
      cyc("imm_u", 32'h12345037, 32'h114, 1, 0, 0, 0, 5'd0, 32'h0,
          32'h12345000);
      cyc("imm_s", 32'hFE112E23, 32'h118, 1, 0, 0, 0, 5'd0, 32'h0,
          32'hFFFFFFFC);
      cyc("imm_none", 32'hFFFFFF8B, 32'h11C, 1, 0, 0, 0, 5'd0, 32'h0,
          32'h0);

      cyc("pre_stall", 32'h00528313, 32'h200, 1, 0, 0, 0, 5'd0, 32'h0,
          32'd5);
      cyc("stall1", 32'h12345037, 32'h204, 1, 1, 0, 1, 5'd9, 32'h99,
          32'h12345000);
      cyc("stall2", 32'h800000EF, 32'h208, 1, 1, 0, 0, 5'd0, 32'h0,
          32'hFFF00000);
      cyc("stall_flush", 32'h800000EF, 32'h208, 1, 1, 1, 0, 5'd0, 32'h0,
          32'hFFF00000);
      cyc("reload", 32'h12345037, 32'h20C, 1, 0, 0, 0, 5'd0, 32'h0,
          32'h12345000);
      cyc("flush", 32'h00528313, 32'h210, 1, 0, 1, 0, 5'd0, 32'h0,
          32'd5);
      cyc("rd_x9", 32'h00048093, 32'h214, 1, 0, 0, 0, 5'd0, 32'h0,
          32'h0);
      cyc("stall_wb5", 32'h0, 32'h218, 1, 1, 0, 1, 5'd9, 32'h55,
          32'h0);
      cyc("after_wb5", 32'h00048093, 32'h21C, 1, 0, 0, 0, 5'd0, 32'h0,
          32'h0);

      cyc("wb_x7", 32'h0, 32'h300, 0, 0, 0, 1, 5'd7, 32'h11, 32'h0);
      cyc("bypass_x7", 32'h00038093, 32'h304, 1, 0, 0, 1, 5'd7, 32'hA5,
          32'h0);
      cyc("rd_x7", 32'h00038093, 32'h308, 1, 0, 0, 0, 5'd0, 32'h0,
          32'h0);
      cyc("invalid", 32'h00528313, 32'h30C, 0, 0, 0, 0, 5'd0, 32'h0,
          32'd5);
      cyc("valid_addi", 32'h00528313, 32'h310, 1, 0, 0, 0, 5'd0, 32'h0,
          32'd5);

      #3;
      reset = 1'b0;
      #1;
      check("reset_mid", '0);
      clear_model();
      @(posedge clk);
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      cyc("rd_x5_post", 32'h00528313, 32'h400, 1, 0, 0, 0, 5'd0, 32'h0,
          32'd5);
      cyc("rd_x7_post", 32'h00038093, 32'h404, 1, 0, 0, 0, 5'd0, 32'h0,
          32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
